// File: rtl/bcd_timer_nd_if.sv
// Control and status bundle for the BCD countdown/countup timer.
// The master drives the command pulses and load value; the slave (timer)
// returns the count and status flags.
interface bcd_timer_nd_if #(
    parameter int DIGITS = 2
);
    logic                  start_stop;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  up_dn;
    logic [4*DIGITS-1:0]   digits;
    logic                  running;
    logic                  done;
    logic                  expired;
    logic                  tick;

    modport master (
        output start_stop, clear, load, load_val, up_dn,
        input  digits, running, done, expired, tick
    );

    modport slave (
        input  start_stop, clear, load, load_val, up_dn,
        output digits, running, done, expired, tick
    );
endinterface

// File: rtl/bcd_timer_nd.sv
// Multi-digit BCD timer with prescaled tick, run/pause control and
// terminal detection in both count directions. The count never wraps past
// 0 (down) or all-9s (up); reaching either parks the timer in DONE.
module bcd_timer_nd #(
    parameter int                  DIGITS   = 2,
    parameter int                  TICK_DIV = 100,
    parameter logic [4*DIGITS-1:0] PRESET   = {DIGITS{4'h9}}
) (
    input  logic           clk,
    input  logic           rst_n,   // active-high asynchronous reset
    bcd_timer_nd_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // A one-cycle divider still needs a 1-bit counter to keep widths legal.
    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [1:0]           state_q, state_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 running_q, done_q, expired_q, tick_q;
    logic                 expired_d, tick_d;

    logic [4*DIGITS-1:0]  load_sat;     // load value with nibbles clamped to 9
    logic [4*DIGITS-1:0]  stepped;      // count after one BCD step in up_dn direction
    logic [DIGITS-1:0]    ripple;       // carry (up) / borrow (down) into each digit
    logic [4*DIGITS-1:0]  terminal;

    assign ripple[0] = 1'b1;
    assign terminal  = bus.up_dn ? ALL_NINES : '0;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            logic       at_edge;    // digit would wrap (9 going up, 0 going down)
            assign nib     = digits_q[4*gi +: 4];
            assign at_edge = bus.up_dn ? (nib == 4'd9) : (nib == 4'd0);
            assign stepped[4*gi +: 4] = !ripple[gi] ? nib :
                                        bus.up_dn   ? (at_edge ? 4'd0 : nib + 4'd1) :
                                                      (at_edge ? 4'd9 : nib - 4'd1);
            assign load_sat[4*gi +: 4] = (bus.load_val[4*gi +: 4] > 4'd9) ? 4'd9
                                                                          : bus.load_val[4*gi +: 4];
            if (gi < DIGITS - 1) begin : g_ripple
                assign ripple[gi+1] = ripple[gi] & at_edge;
            end
        end
    endgenerate

    // Next-state: clear > load > start_stop > tick; only the winner acts.
    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        presc_d   = presc_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        if (bus.clear) begin
            digits_d = PRESET;
            state_d  = IDLE;
            presc_d  = '0;
        end else if (bus.load) begin
            digits_d = load_sat;
            state_d  = IDLE;
            presc_d  = '0;
        end else if (bus.start_stop && state_q != DONE) begin
            // Prescaler holds across the toggle so a resume keeps its phase.
            state_d = (state_q == RUN) ? PAUSE : RUN;
        end else if (state_q == RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (digits_q == terminal) begin
                    // Already at the end for this direction: finish without stepping.
                    state_d   = DONE;
                    expired_d = 1'b1;
                end else begin
                    digits_d = stepped;
                    if (stepped == terminal) begin
                        state_d   = DONE;
                        expired_d = 1'b1;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // State, count and registered status outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            digits_q  <= PRESET;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            presc_q   <= presc_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
            expired_q <= expired_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_bcd_timer_nd.sv
// Bench for bcd_timer_nd: table of cycle vectors, directed corner sequences,
// then random commands checked every cycle against a decimal-arithmetic model.
module tb_bcd_timer_nd;
    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int MAXV     = 99;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    bcd_timer_nd_if #(.DIGITS(DIGITS)) bus ();

    bcd_timer_nd #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .PRESET(8'h99)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count held as a plain decimal integer.
    int m_st, m_val, m_pre;
    bit m_tick, m_exp;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'((v % 10));
        r[7:4] = 4'(((v / 10) % 10));
        return r;
    endfunction

    function automatic int from_bcd_sat(input logic [7:0] b);
        int lo, hi;
        lo = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
        hi = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_val = 99; m_pre = 0; m_tick = 0; m_exp = 0;
    endtask

    task automatic model_step();
        int term;
        m_tick = 0; m_exp = 0;
        if (bus.clear) begin
            m_val = 99; m_st = M_IDLE; m_pre = 0;
        end else if (bus.load) begin
            m_val = from_bcd_sat(bus.load_val); m_st = M_IDLE; m_pre = 0;
        end else if (bus.start_stop && m_st != M_DONE) begin
            m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        end else if (m_st == M_RUN) begin
            if (m_pre == TICK_DIV - 1) begin
                m_pre  = 0;
                m_tick = 1;
                term   = bus.up_dn ? MAXV : 0;
                if (m_val != term) m_val = m_val + (bus.up_dn ? 1 : -1);
                if (m_val == term) begin m_st = M_DONE; m_exp = 1; end
            end else begin
                m_pre++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model samples the same inputs as the DUT, pulses drop, outputs compared.
    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        chk("m_digits",  32'(bus.digits),  32'(to_bcd(m_val)));
        chk("m_running", 32'(bus.running), 32'(m_st == M_RUN));
        chk("m_done",    32'(bus.done),    32'(m_st == M_DONE));
        chk("m_expired", 32'(bus.expired), 32'(m_exp));
        chk("m_tick",    32'(bus.tick),    32'(m_tick));
    endtask

    typedef struct {
        logic       clr, ld, ss, up;
        logic [7:0] lv;
        logic [7:0] d;
        logic       r, dn, e, t;
    } vec_t;

    vec_t vec [27];

    initial begin
        logic [7:0] seen [$];
        logic [7:0] frozen;
        int n;
        bit hit;

        //              clr ld ss up  lv     digits r  dn e  t
        vec[0]  = '{1'b0,1'b0,1'b1,1'b0,8'h00, 8'h99,1'b1,1'b0,1'b0,1'b0};
        vec[1]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 8'h99,1'b1,1'b0,1'b0,1'b0};
        vec[2]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 8'h99,1'b1,1'b0,1'b0,1'b0};
        vec[3]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 8'h99,1'b1,1'b0,1'b0,1'b0};
        vec[4]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 8'h98,1'b1,1'b0,1'b0,1'b1};
        vec[5]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 8'h98,1'b1,1'b0,1'b0,1'b0};
        vec[6]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 8'h98,1'b1,1'b0,1'b0,1'b0};
        vec[7]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 8'h98,1'b1,1'b0,1'b0,1'b0};
        vec[8]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 8'h97,1'b1,1'b0,1'b0,1'b1};
        vec[9]  = '{1'b1,1'b1,1'b0,1'b0,8'h42, 8'h99,1'b0,1'b0,1'b0,1'b0};
        vec[10] = '{1'b0,1'b1,1'b0,1'b0,8'hA3, 8'h93,1'b0,1'b0,1'b0,1'b0};
        vec[11] = '{1'b0,1'b1,1'b0,1'b0,8'h5F, 8'h59,1'b0,1'b0,1'b0,1'b0};
        vec[12] = '{1'b0,1'b0,1'b1,1'b1,8'h00, 8'h59,1'b1,1'b0,1'b0,1'b0};
        vec[13] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 8'h59,1'b1,1'b0,1'b0,1'b0};
        vec[14] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 8'h59,1'b1,1'b0,1'b0,1'b0};
        vec[15] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 8'h59,1'b1,1'b0,1'b0,1'b0};
        vec[16] = '{1'b0,1'b0,1'b1,1'b1,8'h00, 8'h59,1'b0,1'b0,1'b0,1'b0};
        vec[17] = '{1'b0,1'b0,1'b1,1'b1,8'h00, 8'h59,1'b1,1'b0,1'b0,1'b0};
        vec[18] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 8'h60,1'b1,1'b0,1'b0,1'b1};
        vec[19] = '{1'b0,1'b1,1'b0,1'b1,8'h98, 8'h98,1'b0,1'b0,1'b0,1'b0};
        vec[20] = '{1'b0,1'b0,1'b1,1'b1,8'h00, 8'h98,1'b1,1'b0,1'b0,1'b0};
        vec[21] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 8'h98,1'b1,1'b0,1'b0,1'b0};
        vec[22] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 8'h98,1'b1,1'b0,1'b0,1'b0};
        vec[23] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 8'h98,1'b1,1'b0,1'b0,1'b0};
        vec[24] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 8'h99,1'b0,1'b1,1'b1,1'b1};
        vec[25] = '{1'b0,1'b0,1'b1,1'b1,8'h00, 8'h99,1'b0,1'b1,1'b0,1'b0};
        vec[26] = '{1'b1,1'b0,1'b0,1'b0,8'h00, 8'h99,1'b0,1'b0,1'b0,1'b0};

        bus.start_stop = 0; bus.clear = 0; bus.load = 0; bus.load_val = '0; bus.up_dn = 0;
        rst_n = 1'b1;
        model_reset();
        #22;
        chk("rst_digits",  32'(bus.digits),  32'h99);
        chk("rst_running", 32'(bus.running), 32'h0);
        chk("rst_done",    32'(bus.done),    32'h0);
        chk("rst_expired", 32'(bus.expired), 32'h0);
        chk("rst_tick",    32'(bus.tick),    32'h0);
        rst_n = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 27; i++) begin
            bus.clear = vec[i].clr; bus.load = vec[i].ld; bus.start_stop = vec[i].ss;
            bus.up_dn = vec[i].up;  bus.load_val = vec[i].lv;
            clk_step();
            chk("vec_digits",  32'(bus.digits),  32'(vec[i].d));
            chk("vec_running", 32'(bus.running), 32'(vec[i].r));
            chk("vec_done",    32'(bus.done),    32'(vec[i].dn));
            chk("vec_expired", 32'(bus.expired), 32'(vec[i].e));
            chk("vec_tick",    32'(bus.tick),    32'(vec[i].t));
            $display("vec %0d: digits=%h running=%0d done=%0d expired=%0d tick=%0d",
                     i, bus.digits, bus.running, bus.done, bus.expired, bus.tick);
        end

        // Down count from 10 through the borrow to 00, then parked in DONE
        bus.load = 1; bus.load_val = 8'h10; bus.up_dn = 0; clk_step();
        bus.start_stop = 1; clk_step();
        seen.delete(); hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            clk_step();
            if (bus.tick) seen.push_back(bus.digits);
            hit = bus.expired;
        end
        chk("down_expired_seen", 32'(hit), 32'h1);
        chk("down_tick_count", 32'(seen.size()), 32'd10);
        for (int k = 0; k < seen.size() && k < 10; k++)
            chk("down_tick_value", 32'(seen[k]), 32'(to_bcd(9 - k)));
        chk("down_done", 32'(bus.done), 32'h1);
        bus.start_stop = 1; clk_step();
        for (int c = 0; c < 8; c++) clk_step();
        chk("down_hold_digits", 32'(bus.digits), 32'h00);
        chk("down_hold_running", 32'(bus.running), 32'h0);
        $display("seq down: ticks=%0d final=%h done=%0d", seen.size(), bus.digits, bus.done);

        // Up count 97 -> 98 -> 99 and stop
        bus.load = 1; bus.load_val = 8'h97; bus.up_dn = 1; clk_step();
        bus.start_stop = 1; clk_step();
        seen.delete(); hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            clk_step();
            if (bus.tick) seen.push_back(bus.digits);
            hit = bus.expired;
        end
        chk("up_expired_seen", 32'(hit), 32'h1);
        chk("up_tick_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("up_tick0", 32'(seen[0]), 32'h98);
            chk("up_tick1", 32'(seen[1]), 32'h99);
        end
        for (int c = 0; c < 8; c++) clk_step();
        chk("up_no_wrap", 32'(bus.digits), 32'h99);
        $display("seq up: ticks=%0d final=%h", seen.size(), bus.digits);

        // Pause mid-period, hold, resume keeps prescaler phase
        bus.load = 1; bus.load_val = 8'h50; bus.up_dn = 0; clk_step();
        bus.start_stop = 1; clk_step();
        for (int c = 0; c < 6; c++) clk_step();
        bus.start_stop = 1; clk_step();
        frozen = bus.digits;
        chk("pause_running", 32'(bus.running), 32'h0);
        for (int c = 0; c < 20; c++) begin
            clk_step();
            chk("pause_frozen", 32'(bus.digits), 32'(frozen));
        end
        bus.start_stop = 1; clk_step();
        n = 0; hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            clk_step();
            n++;
            hit = bus.tick;
        end
        chk("resume_tick_seen", 32'(hit), 32'h1);
        chk("resume_tick_delay", 32'(n), 32'd2);
        $display("seq pause: frozen=%h resume_delay=%0d", frozen, n);

        // Already at terminal when run starts: DONE on first tick, no step
        bus.load = 1; bus.load_val = 8'h00; bus.up_dn = 0; clk_step();
        bus.start_stop = 1; clk_step();
        for (int c = 0; c < 4; c++) clk_step();
        chk("term_start_digits",  32'(bus.digits),  32'h00);
        chk("term_start_expired", 32'(bus.expired), 32'h1);
        chk("term_start_done",    32'(bus.done),    32'h1);
        $display("seq terminal start: digits=%h done=%0d", bus.digits, bus.done);

        // Asynchronous reset in the middle of a count
        bus.load = 1; bus.load_val = 8'h57; bus.up_dn = 0; clk_step();
        bus.start_stop = 1; clk_step();
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            clk_step();
            hit = (bus.digits == 8'h56);
        end
        chk("async_reach_56", 32'(hit), 32'h1);
        clk_step();
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_digits",  32'(bus.digits),  32'h99);
        chk("async_running", 32'(bus.running), 32'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #3;
        chk("async_hold_digits", 32'(bus.digits), 32'h99);
        rst_n = 1'b0;
        bus.start_stop = 1; clk_step();
        $display("seq async reset: digits=%h running=%0d", bus.digits, bus.running);

        // Random commands against the model
        for (int c = 0; c < 4000; c++) begin
            bus.clear      = ($urandom_range(0, 99) == 0);
            bus.load       = ($urandom_range(0, 39) == 0);
            bus.start_stop = ($urandom_range(0, 15) == 0);
            bus.load_val   = 8'($urandom);
            if ($urandom_range(0, 19) == 0) bus.up_dn = ~bus.up_dn;
            clk_step();
            if (c % 500 == 499)
                $display("random %0d: digits=%h running=%0d done=%0d fails=%0d",
                         c + 1, bus.digits, bus.running, bus.done, n_fail);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
